// File: rtl/io_fifo_responder_if.sv
// Wishbone-style bus bundle between the I/O bridge master port and io_fifo_responder.
interface io_fifo_responder_if;
    logic        cyc_i;
    logic        stb_i;
    logic        ack_o;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/io_fifo_responder.sv
// Bus target draining a producer-filled word FIFO through a DATA register,
// with status/control/command registers and a level-threshold interrupt.
module io_fifo_responder #(
    parameter logic [31:0] IO_ADDR     = 32'hFD0A0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    io_fifo_responder_if.slave   bus,
    input  logic                 dev_wr_i,
    input  logic [31:0]          dev_dat_i,
    output logic                 dev_full_o,
    output logic                 irq_o
);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [3:0]     WS4     = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state;
    logic [3:0]      wcnt;

    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_nx;
    logic            ovf;
    logic            udf;
    logic            irq_en;
    logic [7:0]      thr;

    logic            req;
    logic            fire;
    logic [1:0]      reg_sel;
    logic            empty;
    logic            full;
    logic            pop_ok;
    logic            pop_udf;
    logic            push_ok;
    logic            push_drop;
    logic            flush;
    logic            clr_flags;
    logic            ctrl_wr;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign reg_sel = bus.adr_i[3:2];
    assign req     = bus.cyc_i & bus.stb_i & (bus.adr_i[31:4] == IO_ADDR[31:4]);
    // All register side effects happen on the single edge that enters ACK.
    assign fire    = ((state == S_IDLE) && req && (WAIT_STATES == 0)) ||
                     ((state == S_WAIT) && bus.cyc_i && bus.stb_i && (wcnt == 4'd1));

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    assign dev_full_o = full;

    assign pop_ok    = fire & ~bus.we_i & (reg_sel == 2'd0) & ~empty;
    assign pop_udf   = fire & ~bus.we_i & (reg_sel == 2'd0) & empty;
    assign flush     = fire & bus.we_i & (reg_sel == 2'd3) & bus.dat_i[1];
    assign clr_flags = fire & bus.we_i & (reg_sel == 2'd3) & bus.dat_i[0];
    assign ctrl_wr   = fire & bus.we_i & (reg_sel == 2'd2);
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push_ok   = dev_wr_i & ~flush & (~full | pop_ok);
    assign push_drop = dev_wr_i & ~flush & ~push_ok;
    assign count_nx  = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};

    assign unused_bits = ^{bus.sel_i[3:2], bus.adr_i[1:0], bus.dat_i[31:16], bus.dat_i[7:2]};

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata = empty ? 32'h0 : mem[rd_ptr];
            2'd1: begin
                rdata[31]   = empty;
                rdata[30]   = full;
                rdata[29]   = ovf;
                rdata[28]   = udf;
                rdata[AW:0] = count;
            end
            2'd2: rdata = {16'h0, thr, 7'h0, irq_en};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= dev_dat_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
            irq_en <= 1'b0;
            thr    <= '0;
            irq_o  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
                count <= count_nx;
            end
            // New events in the same cycle as a clear still get recorded.
            ovf <= (ovf & ~clr_flags) | push_drop;
            udf <= (udf & ~clr_flags) | pop_udf;
            if (ctrl_wr && bus.sel_i[0]) irq_en <= bus.dat_i[0];
            if (ctrl_wr && bus.sel_i[1]) thr    <= bus.dat_i[15:8];
            irq_o <= irq_en & ~empty & (count >= thr[AW:0]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            bus.ack_o <= 1'b0;
            bus.dat_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        state     <= S_ACK;
                        bus.ack_o <= 1'b1;
                        bus.dat_o <= bus.we_i ? 32'h0 : rdata;
                    end else if (req) begin
                        state <= S_WAIT;
                        wcnt  <= WS4;
                    end
                end
                S_WAIT: begin
                    if (!(bus.cyc_i && bus.stb_i)) begin
                        state <= S_IDLE;
                    end else if (fire) begin
                        state     <= S_ACK;
                        bus.ack_o <= 1'b1;
                        bus.dat_o <= bus.we_i ? 32'h0 : rdata;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_ACK: begin
                    if (!bus.stb_i) begin
                        state     <= S_IDLE;
                        bus.ack_o <= 1'b0;
                        bus.dat_o <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_fifo_responder.sv
// Directed bench for io_fifo_responder: FIFO reads, status flags, irq threshold,
// aborted/unmatched cycles, held strobe and reset during a transfer.
module tb_io_fifo_responder;
    localparam int          DEPTH = 16;
    localparam int          WS    = 3;
    localparam logic [31:0] BASE  = 32'hFD0A0000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_CMD  = BASE + 32'hC;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dev_wr_i;
    logic [31:0] dev_dat_i;
    logic        dev_full_o;
    logic        irq_o;
    int          n_checks = 0;
    int          n_errors = 0;

    io_fifo_responder_if bus ();

    io_fifo_responder #(.IO_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus),
        .dev_wr_i   (dev_wr_i),
        .dev_dat_i  (dev_dat_i),
        .dev_full_o (dev_full_o),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        @(negedge clk_i);
        dev_wr_i  = 1'b1;
        dev_dat_i = d;
        @(negedge clk_i);
        dev_wr_i  = 1'b0;
    endtask

    // Full transfer: latency, optional held strobe, read data and ack release.
    task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel,
                        input int hold, input logic [31:0] exp);
        int lat;
        lat = 0;
        @(negedge clk_i);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
        bus.adr_i = addr; bus.dat_i = wdata; bus.sel_i = sel;
        while (bus.ack_o !== 1'b1 && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, WS + 1);
        if (!we) check({tag, "_dat"}, bus.dat_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            check({tag, "_hold_ack"}, {31'h0, bus.ack_o}, 32'h1);
            check({tag, "_hold_dat"}, bus.dat_o, exp);
        end
        bus.stb_i = 1'b0; bus.cyc_i = 1'b0; bus.we_i = 1'b0;
        @(posedge clk_i); #1;
        check({tag, "_ack_drop"}, {31'h0, bus.ack_o}, 32'h0);
        check({tag, "_dat_drop"}, bus.dat_o, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        xfer(tag, 1'b0, addr, 32'h0, 4'hF, 0, exp);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] d,
                      input logic [3:0] sel);
        xfer(tag, 1'b1, addr, d, sel, 0, 32'h0);
    endtask

    initial begin
        logic seen;
        int   lat;
        rst_i = 1'b1; dev_wr_i = 1'b0; dev_dat_i = '0;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.sel_i = '0; bus.adr_i = '0; bus.dat_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ack", {31'h0, bus.ack_o}, 32'h0);
        check("rst_dat", bus.dat_o, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        check("rst_full", {31'h0, dev_full_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        push(32'h11); push(32'h22); push(32'h33);
        rd("t1_stat3", A_STAT, 32'h0000_0003);
        rd("t1_rd0", A_DATA, 32'h11);
        rd("t1_rd1", A_DATA, 32'h22);
        rd("t1_rd2", A_DATA, 32'h33);
        rd("t1_stat", A_STAT, 32'h8000_0000);

        for (int i = 0; i < 17; i++) push(32'h100 + i);
        check("t2_full_pin", {31'h0, dev_full_o}, 32'h1);
        rd("t2_stat", A_STAT, 32'h6000_0010);
        rd("t2_pop", A_DATA, 32'h100);
        rd("t2_stat2", A_STAT, 32'h2000_000F);
        wr("t2_flush", A_CMD, 32'h3, 4'hF);
        rd("t2_stat3", A_STAT, 32'h8000_0000);

        rd("t3_empty", A_DATA, 32'h0);
        rd("t3_stat", A_STAT, 32'h9000_0000);
        wr("t3_clr", A_CMD, 32'h1, 4'hF);
        rd("t3_stat2", A_STAT, 32'h8000_0000);

        wr("t4_ctrl", A_CTRL, 32'h0000_0401, 4'hF);
        rd("t4_ctrl_rb", A_CTRL, 32'h0000_0401);
        push(32'hA0); push(32'hA1); push(32'hA2);
        check("t4_irq3", {31'h0, irq_o}, 32'h0);
        push(32'hA3);
        check("t4_irq4_same", {31'h0, irq_o}, 32'h0);
        @(posedge clk_i); #1;
        check("t4_irq4_next", {31'h0, irq_o}, 32'h1);
        rd("t4_pop", A_DATA, 32'hA0);
        check("t4_irq_pop", {31'h0, irq_o}, 32'h0);
        wr("t4_sel", A_CTRL, 32'h0, 4'b0010);
        rd("t4_ctrl_rb2", A_CTRL, 32'h0000_0001);
        check("t4_irq_thr0", {31'h0, irq_o}, 32'h1);
        wr("t4_flush", A_CMD, 32'h2, 4'hF);
        wr("t4_ctrl0", A_CTRL, 32'h0, 4'hF);
        check("t4_irq_off", {31'h0, irq_o}, 32'h0);
        rd("t4_stat", A_STAT, 32'h8000_0000);

        push(32'h55);
        @(negedge clk_i);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = A_DATA;
        seen = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; seen |= bus.ack_o; end
        @(negedge clk_i);
        bus.cyc_i = 1'b0;
        repeat (6) begin @(posedge clk_i); #1; seen |= bus.ack_o; end
        bus.stb_i = 1'b0;
        check("t5_abort_ack", {31'h0, seen}, 32'h0);
        rd("t5_stat", A_STAT, 32'h0000_0001);
        @(negedge clk_i);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 32'hFD0B_0000;
        seen = 1'b0;
        repeat (10) begin @(posedge clk_i); #1; seen |= bus.ack_o; end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        check("t5_nomatch_ack", {31'h0, seen}, 32'h0);
        rd("t5_stat2", A_STAT, 32'h0000_0001);

        push(32'h66);
        xfer("t6_hold", 1'b0, A_DATA, 32'h0, 4'hF, 5, 32'h55);
        rd("t6_stat", A_STAT, 32'h0000_0001);
        rd("t6_next", A_DATA, 32'h66);
        rd("t6_stat2", A_STAT, 32'h8000_0000);

        push(32'h77);
        @(negedge clk_i);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = A_STAT;
        lat = 0;
        while (bus.ack_o !== 1'b1 && lat < 20) begin @(posedge clk_i); #1; lat++; end
        check("t7_ack_up", {31'h0, bus.ack_o}, 32'h1);
        #2 rst_i = 1'b1;
        #1;
        check("t7_rst_ack", {31'h0, bus.ack_o}, 32'h0);
        check("t7_rst_dat", bus.dat_o, 32'h0);
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        rd("t7_stat", A_STAT, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
